rx_block_align: RTL

RX_BLOCK_ALIGN -- requirements
Module: rx_block_align

---
 rtl/rx_block_align_if.sv | 25 ++
 rtl/rx_block_align.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rx_block_align_if.sv
// Bus bundle for rx_block_align: deserializer window and status in, aligned blocks out.
interface rx_block_align_if #(
  parameter int W = 130
);
  logic [W-1:0] win;
  logic         cdr_lock;
  logic         deskew_done;
  logic [127:0] block_data;
  logic         block_type;
  logic         block_valid;
  logic         hdr_err;
  logic         block_lock;
  logic [7:0]   slip_cnt;
  logic [15:0]  err_cnt;

  modport master (
    output win, cdr_lock, deskew_done,
    input  block_data, block_type, block_valid, hdr_err, block_lock, slip_cnt, err_cnt
  );

  modport slave (
    input  win, cdr_lock, deskew_done,
    output block_data, block_type, block_valid, hdr_err, block_lock, slip_cnt, err_cnt
  );
endinterface

// File: rtl/rx_block_align.sv
// Sync-header block aligner: hunts for a 2-bit header boundary in a sliding
// window, slipping one bit per bad header, and strobes payloads once locked.
module rx_block_align #(
  parameter int W          = 130,
  parameter int LOCK_GOOD  = 8,
  parameter int UNLOCK_BAD = 4
) (
  input logic             clk,
  input logic             rst_n,
  rx_block_align_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int PW = $clog2(W);
  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int BW = $clog2(UNLOCK_BAD + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(W - 1);

  state_t        state, nxt_state;
  logic [PW-1:0] phase;
  logic          hold;
  logic [GW-1:0] good_cnt, nxt_good;
  logic [BW-1:0] bad_cnt, nxt_bad;
  logic          in_ok, sample, hdr_ok, last_bad;
  logic          slip, strobe;
  logic [1:0]    hdr;

  assign in_ok    = bus.cdr_lock & bus.deskew_done;
  assign hdr      = bus.win[W-1:W-2];
  assign hdr_ok   = (hdr == 2'b10) || (hdr == 2'b01);
  assign sample   = in_ok && (phase == PH_LAST) && !hold;
  assign last_bad = (bad_cnt == BW'(UNLOCK_BAD - 1));

  // Phase counter; a slip parks phase at W-1 for one extra (non-sampling) cycle
  // via the hold flag, pushing the next sample point one bit later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      hold  <= 1'b0;
    end else if (!in_ok) begin
      phase <= '0;
      hold  <= 1'b0;
    end else if (slip) begin
      hold  <= 1'b1;
    end else begin
      hold  <= 1'b0;
      phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
    end
  end

  // Alignment state and header run counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= nxt_state;
      good_cnt <= nxt_good;
      bad_cnt  <= nxt_bad;
    end
  end

  // Next-state and counter update on each sample point.
  always_comb begin
    nxt_state = state;
    nxt_good  = good_cnt;
    nxt_bad   = bad_cnt;
    if (!in_ok) begin
      nxt_state = HUNT;
      nxt_good  = '0;
      nxt_bad   = '0;
    end else if (sample) begin
      unique case (state)
        HUNT: begin
          if (hdr_ok) begin
            nxt_state = (LOCK_GOOD == 1) ? LOCKED : CHECK;
            nxt_good  = (LOCK_GOOD == 1) ? '0 : GW'(1);
            nxt_bad   = '0;
          end
        end
        CHECK: begin
          if (!hdr_ok) begin
            nxt_state = HUNT;
            nxt_good  = '0;
          end else if (good_cnt == GW'(LOCK_GOOD - 1)) begin
            nxt_state = LOCKED;
            nxt_good  = '0;
            nxt_bad   = '0;
          end else begin
            nxt_good  = good_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (hdr_ok) begin
            nxt_bad = '0;
          end else if (last_bad) begin
            nxt_state = HUNT;
            nxt_bad   = '0;
            nxt_good  = '0;
          end else begin
            nxt_bad = bad_cnt + 1'b1;
          end
        end
        default: begin
          nxt_state = HUNT;
          nxt_good  = '0;
          nxt_bad   = '0;
        end
      endcase
    end
  end

  // Per-sample actions: slip requests and payload strobes.
  always_comb begin
    slip   = 1'b0;
    strobe = 1'b0;
    if (sample) begin
      unique case (state)
        HUNT, CHECK: slip = !hdr_ok;
        LOCKED: begin
          strobe = 1'b1;
          slip   = !hdr_ok && last_bad;
        end
        default: slip = 1'b0;
      endcase
    end
  end

  // Registered outputs, one cycle after the sample point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.block_data  <= '0;
      bus.block_type  <= 1'b0;
      bus.block_valid <= 1'b0;
      bus.hdr_err     <= 1'b0;
      bus.block_lock  <= 1'b0;
      bus.slip_cnt    <= '0;
      bus.err_cnt     <= '0;
    end else begin
      bus.block_valid <= strobe;
      bus.hdr_err     <= strobe && !hdr_ok;
      bus.block_lock  <= (nxt_state == LOCKED);
      if (strobe) begin
        bus.block_data <= bus.win[127:0];
        bus.block_type <= (hdr == 2'b01);
      end
      if (slip && (bus.slip_cnt != '1)) begin
        bus.slip_cnt <= bus.slip_cnt + 1'b1;
      end
      if (strobe && !hdr_ok && (bus.err_cnt != '1)) begin
        bus.err_cnt <= bus.err_cnt + 1'b1;
      end
    end
  end

endmodule
